// File: rtl/m_prog_loader.sv
// m_prog_loader: byte-stream program loader that writes 32-bit words into
// instruction memory and then releases the processor clock enable.
// Stream format: count low byte, count high byte, 4*N payload bytes
// (little-endian words), then one checksum byte when LOADER_CSUM_EN is defined.
// Ports:
//   w_clk, w_rst             clock, asynchronous active-high reset
//   w_rx_valid/data/ready    byte input handshake
//   w_mem_we/addr/din        memory write port (registered, one-cycle strobe)
//   w_ce                     processor clock enable, high only in RUN
//   w_err                    sticky failure flag, high only in ERR
// Config macro: LOADER_CSUM_EN enables the trailing checksum byte and its check.
module m_prog_loader #(
    parameter int          MAX_WORDS = 4096,
    parameter logic [11:0] BASE_ADDR = 12'h000
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        w_rx_valid,
    input  logic [7:0]  w_rx_data,
    output logic        w_rx_ready,
    output logic        w_mem_we,
    output logic [11:0] w_mem_addr,
    output logic [31:0] w_mem_din,
    output logic        w_ce,
    output logic        w_err
);
    typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, RUN, ERR} state_t;

    state_t      state_q, state_d;
    logic [7:0]  low_q, low_d;
    logic [15:0] len_q, len_d;
    logic [1:0]  byte_q, byte_d;
    logic [15:0] word_q, word_d;
    logic [23:0] part_q, part_d;
    logic        we_q, we_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic        xfer;
    logic [15:0] n;
    logic        last_byte;
`ifdef LOADER_CSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    assign xfer      = w_rx_valid && w_rx_ready;
    assign n         = {w_rx_data, low_q};
    assign last_byte = (byte_q == 2'd3) && (word_q == len_q - 16'd1);

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) state_q <= LEN0;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LEN0: if (xfer) state_d = LEN1;
            LEN1: if (xfer) state_d = (n == 16'd0) ? RUN : (32'(n) > MAX_WORDS) ? ERR : DATA;
`ifdef LOADER_CSUM_EN
            DATA: if (xfer && last_byte) state_d = CSUM;
            CSUM: if (xfer) state_d = (w_rx_data == csum_q) ? RUN : ERR;
`else
            DATA: if (xfer && last_byte) state_d = RUN;
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_rx_ready = (state_q == LEN0) || (state_q == LEN1) || (state_q == DATA) || (state_q == CSUM);
        w_ce       = (state_q == RUN);
        w_err      = (state_q == ERR);
        w_mem_we   = we_q;
        w_mem_addr = addr_q;
        w_mem_din  = din_q;
        low_d      = (xfer && state_q == LEN0) ? w_rx_data : low_q;
        len_d      = (xfer && state_q == LEN1) ? n : len_q;
        byte_d     = byte_q;
        word_d     = word_q;
        part_d     = part_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        din_d      = din_q;
`ifdef LOADER_CSUM_EN
        csum_d     = csum_q;
`endif
        if (xfer && state_q == DATA) begin
            byte_d = byte_q + 2'd1;
            // Shift right so that after three bytes part_q holds {b2, b1, b0}.
            part_d = {w_rx_data, part_q[23:8]};
`ifdef LOADER_CSUM_EN
            csum_d = csum_q + w_rx_data;
`endif
            if (byte_q == 2'd3) begin
                we_d   = 1'b1;
                addr_d = BASE_ADDR + word_q[11:0];
                din_d  = {w_rx_data, part_q};
                word_d = word_q + 16'd1;
            end
        end
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            low_q  <= '0;
            len_q  <= '0;
            byte_q <= '0;
            word_q <= '0;
            part_q <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
`ifdef LOADER_CSUM_EN
            csum_q <= '0;
`endif
        end else begin
            low_q  <= low_d;
            len_q  <= len_d;
            byte_q <= byte_d;
            word_q <= word_d;
            part_q <= part_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            din_q  <= din_d;
`ifdef LOADER_CSUM_EN
            csum_q <= csum_d;
`endif
        end
    end
endmodule

// File: tb/tb_m_prog_loader.sv
// tb_m_prog_loader: directed self-checking bench for m_prog_loader.
module tb_m_prog_loader;
    logic        w_clk = 1'b0;
    logic        w_rst = 1'b0;
    logic        w_rx_valid = 1'b0;
    logic [7:0]  w_rx_data = 8'h00;
    logic        w_rx_ready;
    logic        w_mem_we;
    logic [11:0] w_mem_addr;
    logic [31:0] w_mem_din;
    logic        w_ce;
    logic        w_err;

    int          n_chk = 0;
    int          n_fail = 0;
    int          stalls = 0;
    int          base = 0;
    logic [11:0] wa[$];
    logic [31:0] wd[$];

    m_prog_loader dut (
        .w_clk(w_clk), .w_rst(w_rst), .w_rx_valid(w_rx_valid), .w_rx_data(w_rx_data),
        .w_rx_ready(w_rx_ready), .w_mem_we(w_mem_we), .w_mem_addr(w_mem_addr),
        .w_mem_din(w_mem_din), .w_ce(w_ce), .w_err(w_err)
    );

    always #5 w_clk = ~w_clk;

    always @(negedge w_clk) begin
        if (w_mem_we === 1'b1) begin
            wa.push_back(w_mem_addr);
            wd.push_back(w_mem_din);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge w_clk);
        if (w_rx_ready !== 1'b1) stalls++;
        w_rx_valid = 1'b1;
        w_rx_data  = b;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge w_clk);
            w_rx_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge w_clk);
        w_rx_valid = 1'b0;
        w_rst = 1'b1;
        #1;
        check("rst_we", 32'(w_mem_we), 32'd0);
        check("rst_ready", 32'(w_rx_ready), 32'd1);
        @(negedge w_clk);
        w_rst = 1'b0;
        base = wa.size();
        stalls = 0;
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_addr", 32'(w_mem_addr), 32'h0);
        check("rst_din", w_mem_din, 32'h0);
        check("rst_ce", 32'(w_ce), 32'd0);
        check("rst_err", 32'(w_err), 32'd0);

        // Single word load
        send(8'h01); send(8'h00); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
`ifdef LOADER_CSUM_EN
        send(8'h14);
`endif
        #1;
        check("t1_ce_before", 32'(w_ce), 32'd0);
        idle(2);
        check("t1_ce", 32'(w_ce), 32'd1);
        check("t1_err", 32'(w_err), 32'd0);
        check("t1_ready", 32'(w_rx_ready), 32'd0);
        check("t1_nwr", 32'(wa.size() - base), 32'd1);
        if (wa.size() > base) begin
            check("t1_addr", 32'(wa[base]), 32'h000);
            check("t1_din", wd[base], 32'h12345678);
        end

        // Two words at one byte per cycle
        do_reset();
        send(8'h02); send(8'h00);
        for (int i = 1; i <= 8; i++) send(8'(i));
`ifdef LOADER_CSUM_EN
        send(8'h24);
`endif
        idle(2);
        check("t2_stalls", 32'(stalls), 32'd0);
        check("t2_err", 32'(w_err), 32'd0);
        check("t2_ce", 32'(w_ce), 32'd1);
        check("t2_nwr", 32'(wa.size() - base), 32'd2);
        if (wa.size() >= base + 2) begin
            check("t2_addr0", 32'(wa[base]), 32'h000);
            check("t2_din0", wd[base], 32'h04030201);
            check("t2_addr1", 32'(wa[base + 1]), 32'h001);
            check("t2_din1", wd[base + 1], 32'h08070605);
        end

`ifdef LOADER_CSUM_EN
        // Bad checksum
        do_reset();
        send(8'h01); send(8'h00); send(8'h78); send(8'h56); send(8'h34); send(8'h12); send(8'h15);
        idle(1);
        check("t3_err", 32'(w_err), 32'd1);
        check("t3_ce", 32'(w_ce), 32'd0);
        check("t3_ready", 32'(w_rx_ready), 32'd0);
        send(8'h00); send(8'h00);
        idle(2);
        check("t3_err_sticky", 32'(w_err), 32'd1);
        check("t3_ready_sticky", 32'(w_rx_ready), 32'd0);
`endif

        // Oversized length
        do_reset();
        send(8'h01); send(8'h10);
        idle(1);
        check("t4_err", 32'(w_err), 32'd1);
        check("t4_ready", 32'(w_rx_ready), 32'd0);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        idle(2);
        check("t4_nwr", 32'(wa.size() - base), 32'd0);
        check("t4_ce", 32'(w_ce), 32'd0);

        // Largest accepted length enters DATA
        do_reset();
        send(8'h00); send(8'h10);
        idle(1);
        check("t4b_err", 32'(w_err), 32'd0);
        check("t4b_ready", 32'(w_rx_ready), 32'd1);

        // Reset mid-word, then fresh load
        do_reset();
        send(8'h02); send(8'h00); send(8'hAA); send(8'hBB);
        do_reset();
        send(8'h01); send(8'h00); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
`ifdef LOADER_CSUM_EN
        send(8'h14);
`endif
        idle(2);
        check("t5_nwr", 32'(wa.size() - base), 32'd1);
        if (wa.size() > base) begin
            check("t5_addr", 32'(wa[base]), 32'h000);
            check("t5_din", wd[base], 32'h12345678);
        end
        check("t5_ce", 32'(w_ce), 32'd1);

        // Zero length
        do_reset();
        send(8'h00); send(8'h00);
        idle(1);
        check("t6_ce", 32'(w_ce), 32'd1);
        check("t6_ready", 32'(w_rx_ready), 32'd0);
        send(8'h01); send(8'h00); send(8'h55); send(8'h66); send(8'h77); send(8'h88);
        idle(2);
        check("t6_ce_hold", 32'(w_ce), 32'd1);
        check("t6_err", 32'(w_err), 32'd0);
        check("t6_nwr", 32'(wa.size() - base), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/m_prog_loader.md
M_PROG_LOADER -- requirements
Module: m_prog_loader

Interface
REQ-001 Parameter: MAX_WORDS, default 4096, largest accepted program length in 32-bit words.
REQ-002 Parameter: BASE_ADDR, default 12'h000, word address of the first word written.
REQ-003 Port: w_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: w_rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: w_rx_valid  input  1  a byte is offered on w_rx_data.
REQ-006 Port: w_rx_data  input  8  offered byte.
REQ-007 Port: w_rx_ready  output  1  loader accepts a byte; a transfer occurs on a rising edge where valid and ready are both 1.
REQ-008 Port: w_mem_we  output  1  write strobe to the memory write port.
REQ-009 Port: w_mem_addr  output  12  word address for the write.
REQ-010 Port: w_mem_din  output  32  write data.
REQ-011 Port: w_ce  output  1  processor clock enable; 1 only after a successful load.
REQ-012 Port: w_err  output  1  sticky load-failure flag.

Function
REQ-013 States SHALL be: LEN0, LEN1, DATA, CSUM, RUN, ERR.
REQ-014 LEN0: on transfer, latch the count low byte and go to LEN1.
REQ-015 LEN1: on transfer, form the count N = {byte, low}. N==0 goes to RUN. N>MAX_WORDS goes to ERR. Otherwise go to DATA.
REQ-016 DATA: bytes are packed little-endian. The first byte of a word goes to din[7:0], the fourth to din[31:24].
REQ-017 On the transfer of the 4th byte of a word, the following cycle SHALL drive we=1 for exactly one cycle, with addr = BASE_ADDR + word index (mod 4096) and din = the assembled word.
REQ-018 A new byte may be accepted in the same cycle as that write; back-to-back transfers at 1 byte/cycle SHALL be sustained with no bubbles.
REQ-019 After the 4th byte of word N-1, the FSM goes to CSUM.
REQ-020 CSUM: on transfer, compare the byte with the mod-256 sum of all 4N payload bytes (length bytes excluded). Equal goes to RUN; unequal goes to ERR.
REQ-021 w_rx_ready SHALL be 1 in LEN0, LEN1, DATA and CSUM, and 0 in RUN and ERR.
REQ-022 Bytes offered in RUN or ERR are ignored, and no state changes.
REQ-023 w_ce SHALL be 1 exactly while in RUN. RUN and ERR are terminal until reset.
REQ-024 w_err SHALL be 1 exactly while in ERR.
REQ-025 w_mem_we SHALL be 0 in every cycle other than those defined in REQ-017.
REQ-026 A word index wrapping past 4095 wraps the address modulo 4096; no error is raised.

Reset
REQ-027 While w_rst=1, state SHALL be LEN0, with we=0, addr=0, din=0, w_ce=0, w_err=0, and the byte counter, word counter and checksum all 0.
REQ-028 Reset mid-load SHALL discard any partial word. Words already written remain in memory. A pending write in the cycle reset asserts is suppressed.
REQ-029 The first transfer after reset deassertion SHALL be treated as the LEN0 byte.

Configuration
REQ-030 Macro LOADER_CSUM_EN. When defined: CSUM state and checking as in REQ-020. When undefined: the last data byte goes directly to RUN, no checksum byte is consumed, and ERR is reachable only via REQ-015.

Verification
REQ-031 N=1, bytes 01 00 | 78 56 34 12 | csum 14. The bench SHALL see exactly one write pulse with addr 000 and din 32'h12345678, and w_ce=1 from the cycle after the checksum transfer.
REQ-032 N=2, valid held high, 10 bytes total. Writes to 000 and 001 SHALL occur with no stalls (ready continuously 1), and w_err=0.
REQ-033 N=1 with bad checksum 15 (macro on). The bench SHALL see w_err=1, w_ce=0, and w_rx_ready=0 thereafter.
REQ-034 Length 01 10 (N=4097). The FSM SHALL go to ERR immediately, with no writes.
REQ-035 Reset asserted after 2 data bytes, then a fresh N=1 load. There SHALL be no write from the aborted word, and the new word is written to addr 000.
REQ-036 Length 00 00. The FSM SHALL go to RUN with w_ce=1 and no writes; later offered bytes are ignored.
